// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags; receives ROB commits,
// issue-stage renames and serves two combinational decoder operand queries.
module reg_file #(
    parameter int REG_NUM       = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ROB_POS_WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic                        clr,
    input  logic                        rob_to_reg_enable,
    input  logic [$clog2(REG_NUM)-1:0]  rob_to_reg_rd,
    input  logic [DATA_WIDTH-1:0]       rob_to_reg_val,
    input  logic [ROB_POS_WIDTH:0]      commit_rob_pos,
    input  logic                        issue_to_reg_enable,
    input  logic [$clog2(REG_NUM)-1:0]  issue_to_reg_rd,
    input  logic [ROB_POS_WIDTH:0]      issue_to_reg_rob_pos,
    input  logic [$clog2(REG_NUM)-1:0]  dc_to_reg_rs1_pos,
    input  logic [$clog2(REG_NUM)-1:0]  dc_to_reg_rs2_pos,
    output logic [DATA_WIDTH-1:0]       reg_to_dc_rs1_val,
    output logic [DATA_WIDTH-1:0]       reg_to_dc_rs2_val,
    output logic [ROB_POS_WIDTH:0]      reg_to_dc_rs1_rob_pos,
    output logic [ROB_POS_WIDTH:0]      reg_to_dc_rs2_rob_pos
);

    localparam int IDX_W = $clog2(REG_NUM);

    logic [DATA_WIDTH-1:0]  val_q [REG_NUM];
    logic [ROB_POS_WIDTH:0] tag_q [REG_NUM];

    logic commit_we;
    logic rename_we;

    assign commit_we = rob_to_reg_enable && (rob_to_reg_rd != '0);
    assign rename_we = issue_to_reg_enable && (issue_to_reg_rd != '0);

    // Statement order encodes priority: clr beats rename, rename beats the commit tag clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (rdy) begin
            if (commit_we) begin
                val_q[rob_to_reg_rd] <= rob_to_reg_val;
                if (tag_q[rob_to_reg_rd] == commit_rob_pos)
                    tag_q[rob_to_reg_rd] <= '0;
            end
            if (clr) begin
                for (int unsigned i = 0; i < REG_NUM; i++)
                    tag_q[i] <= '0;
            end else if (rename_we) begin
                tag_q[issue_to_reg_rd] <= issue_to_reg_rob_pos;
            end
        end
    end

    always_comb begin
        reg_to_dc_rs1_val     = '0;
        reg_to_dc_rs1_rob_pos = '0;
        if (dc_to_reg_rs1_pos != '0) begin
            if (commit_we && rob_to_reg_rd == dc_to_reg_rs1_pos
                && tag_q[dc_to_reg_rs1_pos] == commit_rob_pos) begin
                reg_to_dc_rs1_val = rob_to_reg_val;
            end else begin
                reg_to_dc_rs1_val     = val_q[dc_to_reg_rs1_pos];
                reg_to_dc_rs1_rob_pos = tag_q[dc_to_reg_rs1_pos];
            end
        end
    end

    always_comb begin
        reg_to_dc_rs2_val     = '0;
        reg_to_dc_rs2_rob_pos = '0;
        if (dc_to_reg_rs2_pos != '0) begin
            if (commit_we && rob_to_reg_rd == dc_to_reg_rs2_pos
                && tag_q[dc_to_reg_rs2_pos] == commit_rob_pos) begin
                reg_to_dc_rs2_val = rob_to_reg_val;
            end else begin
                reg_to_dc_rs2_val     = val_q[dc_to_reg_rs2_pos];
                reg_to_dc_rs2_rob_pos = tag_q[dc_to_reg_rs2_pos];
            end
        end
    end

    // Unused index width parameter guard keeps IDX_W referenced for readers sizing ports.
    logic [IDX_W-1:0] unused_idx;
    assign unused_idx = '0;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, rename/commit, stale commit,
// same-cycle commit+rename, flush, x0 and rdy hold.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst, rdy, clr;
    logic        rob_to_reg_enable;
    logic [4:0]  rob_to_reg_rd;
    logic [31:0] rob_to_reg_val;
    logic [4:0]  commit_rob_pos;
    logic        issue_to_reg_enable;
    logic [4:0]  issue_to_reg_rd;
    logic [4:0]  issue_to_reg_rob_pos;
    logic [4:0]  dc_to_reg_rs1_pos, dc_to_reg_rs2_pos;
    logic [31:0] reg_to_dc_rs1_val, reg_to_dc_rs2_val;
    logic [4:0]  reg_to_dc_rs1_rob_pos, reg_to_dc_rs2_rob_pos;

    int unsigned total = 0;
    int unsigned bad   = 0;

    reg_file #(.REG_NUM(32), .DATA_WIDTH(32), .ROB_POS_WIDTH(4)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .rdy                   (rdy),
        .clr                   (clr),
        .rob_to_reg_enable     (rob_to_reg_enable),
        .rob_to_reg_rd         (rob_to_reg_rd),
        .rob_to_reg_val        (rob_to_reg_val),
        .commit_rob_pos        (commit_rob_pos),
        .issue_to_reg_enable   (issue_to_reg_enable),
        .issue_to_reg_rd       (issue_to_reg_rd),
        .issue_to_reg_rob_pos  (issue_to_reg_rob_pos),
        .dc_to_reg_rs1_pos     (dc_to_reg_rs1_pos),
        .dc_to_reg_rs2_pos     (dc_to_reg_rs2_pos),
        .reg_to_dc_rs1_val     (reg_to_dc_rs1_val),
        .reg_to_dc_rs2_val     (reg_to_dc_rs2_val),
        .reg_to_dc_rs1_rob_pos (reg_to_dc_rs1_rob_pos),
        .reg_to_dc_rs2_rob_pos (reg_to_dc_rs2_rob_pos)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after each rising edge, well away from the next one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rob_to_reg_enable   = 1'b0;
        issue_to_reg_enable = 1'b0;
        clr                 = 1'b0;
    endtask

    task automatic rename(input logic [4:0] rd, input logic [4:0] pos);
        issue_to_reg_enable  = 1'b1;
        issue_to_reg_rd      = rd;
        issue_to_reg_rob_pos = pos;
    endtask

    task automatic commit(input logic [4:0] rd, input logic [31:0] v, input logic [4:0] pos);
        rob_to_reg_enable = 1'b1;
        rob_to_reg_rd     = rd;
        rob_to_reg_val    = v;
        commit_rob_pos    = pos;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1;
        idle();
        rob_to_reg_rd = '0; rob_to_reg_val = '0; commit_rob_pos = '0;
        issue_to_reg_rd = '0; issue_to_reg_rob_pos = '0;
        dc_to_reg_rs1_pos = '0; dc_to_reg_rs2_pos = '0;
        #1;
        tick(); tick();
        rst = 1'b1;

        // Reset state
        dc_to_reg_rs1_pos = 5'd5; dc_to_reg_rs2_pos = 5'd31; #1;
        check("rst_rs1_val", reg_to_dc_rs1_val, 32'h0);
        check("rst_rs1_tag", 32'(reg_to_dc_rs1_rob_pos), 32'h0);
        check("rst_rs2_val", reg_to_dc_rs2_val, 32'h0);
        check("rst_rs2_tag", 32'(reg_to_dc_rs2_rob_pos), 32'h0);

        // Rename then commit with bypass
        rename(5'd3, 5'h12); tick(); idle();
        dc_to_reg_rs1_pos = 5'd3; #1;
        check("ren_x3_tag", 32'(reg_to_dc_rs1_rob_pos), 32'h12);
        commit(5'd3, 32'hDEADBEEF, 5'h12); #1;
        check("byp_x3_val", reg_to_dc_rs1_val, 32'hDEADBEEF);
        check("byp_x3_tag", 32'(reg_to_dc_rs1_rob_pos), 32'h0);
        tick(); idle(); #1;
        check("cmt_x3_val", reg_to_dc_rs1_val, 32'hDEADBEEF);
        check("cmt_x3_tag", 32'(reg_to_dc_rs1_rob_pos), 32'h0);

        // Stale commit keeps the younger tag
        rename(5'd7, 5'h11); tick();
        rename(5'd7, 5'h13); tick(); idle();
        dc_to_reg_rs2_pos = 5'd7;
        commit(5'd7, 32'd5, 5'h11); #1;
        check("stale_nobyp_val", reg_to_dc_rs2_val, 32'h0);
        check("stale_nobyp_tag", 32'(reg_to_dc_rs2_rob_pos), 32'h13);
        tick(); idle(); #1;
        check("stale_x7_val", reg_to_dc_rs2_val, 32'd5);
        check("stale_x7_tag", 32'(reg_to_dc_rs2_rob_pos), 32'h13);

        // Same-cycle commit and rename: rename owns the tag
        rename(5'd4, 5'h14); tick(); idle();
        dc_to_reg_rs1_pos = 5'd4;
        commit(5'd4, 32'd9, 5'h14); rename(5'd4, 5'h15); #1;
        check("same_byp_val", reg_to_dc_rs1_val, 32'd9);
        check("same_byp_tag", 32'(reg_to_dc_rs1_rob_pos), 32'h0);
        tick(); idle(); #1;
        check("same_x4_val", reg_to_dc_rs1_val, 32'd9);
        check("same_x4_tag", 32'(reg_to_dc_rs1_rob_pos), 32'h15);

        // Flush drops all tags and a same-cycle rename
        rename(5'd1, 5'h10); tick();
        rename(5'd2, 5'h1F); tick(); idle();
        dc_to_reg_rs1_pos = 5'd1; dc_to_reg_rs2_pos = 5'd2; #1;
        check("pre_clr_x1_tag", 32'(reg_to_dc_rs1_rob_pos), 32'h10);
        check("pre_clr_x2_tag", 32'(reg_to_dc_rs2_rob_pos), 32'h1F);
        clr = 1'b1; rename(5'd5, 5'h16); tick(); idle(); #1;
        check("clr_x1_tag", 32'(reg_to_dc_rs1_rob_pos), 32'h0);
        check("clr_x2_tag", 32'(reg_to_dc_rs2_rob_pos), 32'h0);
        dc_to_reg_rs1_pos = 5'd5; dc_to_reg_rs2_pos = 5'd7; #1;
        check("clr_x5_tag", 32'(reg_to_dc_rs1_rob_pos), 32'h0);
        check("clr_x7_tag", 32'(reg_to_dc_rs2_rob_pos), 32'h0);
        check("clr_x7_val", reg_to_dc_rs2_val, 32'd5);
        dc_to_reg_rs1_pos = 5'd4; dc_to_reg_rs2_pos = 5'd3; #1;
        check("clr_x4_tag", 32'(reg_to_dc_rs1_rob_pos), 32'h0);
        check("clr_x4_val", reg_to_dc_rs1_val, 32'd9);
        check("clr_x3_val", reg_to_dc_rs2_val, 32'hDEADBEEF);

        // x0 is immune to commit and rename
        dc_to_reg_rs1_pos = 5'd0;
        commit(5'd0, 32'h0000FFFF, 5'h0); rename(5'd0, 5'h18); #1;
        check("x0_byp_val", reg_to_dc_rs1_val, 32'h0);
        check("x0_byp_tag", 32'(reg_to_dc_rs1_rob_pos), 32'h0);
        tick(); idle(); #1;
        check("x0_val", reg_to_dc_rs1_val, 32'h0);
        check("x0_tag", 32'(reg_to_dc_rs1_rob_pos), 32'h0);

        // rdy low holds all state
        rdy = 1'b0;
        commit(5'd6, 32'd1, 5'h0); rename(5'd8, 5'h19);
        tick(); idle(); rdy = 1'b1;
        dc_to_reg_rs1_pos = 5'd6; dc_to_reg_rs2_pos = 5'd8; #1;
        check("hold_x6_val", reg_to_dc_rs1_val, 32'h0);
        check("hold_x8_tag", 32'(reg_to_dc_rs2_rob_pos), 32'h0);
        commit(5'd6, 32'd1, 5'h1A); tick(); idle(); #1;
        check("rdy_x6_val", reg_to_dc_rs1_val, 32'd1);

        // Reset wins over rdy low
        rdy = 1'b0; rst = 1'b0; tick(); rst = 1'b1; rdy = 1'b1;
        dc_to_reg_rs1_pos = 5'd3; dc_to_reg_rs2_pos = 5'd6; #1;
        check("rst2_x3_val", reg_to_dc_rs1_val, 32'h0);
        check("rst2_x6_val", reg_to_dc_rs2_val, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file with rename tags; it is the receiving end of the reorder buffer's commit port. It holds 32 integer registers and one dependency tag per register. The tag names the in-flight ROB entry that will produce the register's value. The decoder queries it for rs1/rs2 operands, and the issue stage renames rd. Committed results from the ROB write values and retire tags. A ROB flush (`clr`) discards all tags.

## Interface
Parameters:
- `REG_NUM`, 32, number of architectural registers; x0 is hardwired to zero.
- `DATA_WIDTH`, 32, register value width.
- `ROB_POS_WIDTH`, 4, ROB index width. Wrapped tag width is `ROB_POS_WIDTH+1`. Tag MSB=1 means the tag is valid; tag value 0 means no dependency.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `rdy`  in  1  global ready; when low, all state holds.
- `clr`  in  1  ROB flush; clears every tag.
- `rob_to_reg_enable`  in  1  commit write strobe.
- `rob_to_reg_rd`  in  5  commit destination register.
- `rob_to_reg_val`  in  32  commit value.
- `commit_rob_pos`  in  5  wrapped tag of the committing ROB entry.
- `issue_to_reg_enable`  in  1  rename strobe.
- `issue_to_reg_rd`  in  5  register being renamed.
- `issue_to_reg_rob_pos`  in  5  new wrapped tag for that register.
- `dc_to_reg_rs1_pos`, `dc_to_reg_rs2_pos`  in  5  source register indices.
- `reg_to_dc_rs1_val`, `reg_to_dc_rs2_val`  out  32  source values; valid when the matching tag output is 0.
- `reg_to_dc_rs1_rob_pos`, `reg_to_dc_rs2_rob_pos`  out  5  pending producer tag; 0 means the value is final.

## Operation
- **State:** `val[0..31]` and `tag[0..31]`.
  - `val[0]` and `tag[0]` are always 0. Writes and renames targeting x0 are ignored.
- **Reset** (`rst`=0 at an edge): all `val` and all `tag` are set to 0. `rst` has priority over `rdy` and `clr`.
- **`rdy`=0:** no state change. Query outputs still reflect the current state combinationally.
- **Commit** (`rob_to_reg_enable`=1, rd≠0):
  - `val[rd]` ← `rob_to_reg_val`, unconditionally. The ROB commits in order, so this is the architectural value.
  - `tag[rd]` ← 0 only if `tag[rd]` == `commit_rob_pos`. Otherwise a younger rename owns the register and `tag[rd]` is kept.
- **Rename** (`issue_to_reg_enable`=1, rd≠0): `tag[rd]` ← `issue_to_reg_rob_pos`.
- **Same-cycle commit and rename to the same rd:** the rename wins the tag. The value write still happens.
- **`clr`=1 at an edge:** all `tag` ← 0. Any rename in that cycle is dropped. A commit in that cycle still writes `val`.
- **Query** (combinational, per source s):
  - s==0: returns val 0, tag 0.
  - Commit bypass: if `rob_to_reg_enable` && `rob_to_reg_rd`==s && `tag[s]`==`commit_rob_pos`, return `rob_to_reg_val` with tag 0.
  - Otherwise return `val[s]` and `tag[s]`.
  - The query never bypasses a same-cycle rename. The decoder reads operands before its own rd is renamed.

## Timing
- Query latency: 0 cycles (combinational).
- Commit and rename become visible in stored state at the next rising edge. A commit is also visible through the bypass in its own cycle.
- Reset values: every output is 0 after reset, for any query index.
- Throughput: one commit plus one rename per cycle, no stalls. No handshake back to either producer.
- Priority at an edge: `rst` > `rdy`=0 hold > `clr` tag clear > rename > commit tag clear. The commit value write is independent of this priority.
- Tag wrap: tags are compared on the full 5 bits. An entry reused after ROB wrap carries the same tag. This is safe because an older commit with that tag has already retired.

## Test plan
- **Reset:** drive `rst`=0 for 2 cycles, then query rs1=5, rs2=31 -> val 0, tag 0 on both outputs.
- **Rename then commit:**
  - Rename x3 to tag 0x12 -> next cycle rs1=3 gives tag 0x12.
  - Commit x3=0xDEADBEEF with pos 0x12 -> same cycle rs1 gives val 0xDEADBEEF, tag 0 (bypass); next cycle stored val 0xDEADBEEF, tag 0.
- **Stale commit:**
  - Rename x7 to 0x11, then x7 to 0x13.
  - Commit x7=5 with pos 0x11 -> `val[7]`=5, tag stays 0x13, and query returns tag 0x13.
- **Same-cycle commit and rename:** with x4 tag 0x14, commit x4=9 pos 0x14 while renaming x4 to 0x15 -> next cycle tag 0x15, val 9.
- **Flush:**
  - Rename x1→0x10 and x2→0x1F.
  - Assert `clr` together with a rename x5→0x16 -> all tags 0, including x5; earlier values unchanged.
- **x0 and `rdy`:**
  - Commit x0=0xFFFF and rename x0→0x18 -> query x0 gives 0/0.
  - With `rdy`=0, commit x6=1 -> `val[6]` unchanged after the edge.
